// File: rtl/axi_wr_route_ctrl.sv
// Write-path routing controller: steers one AXI master's AW/W/B channels to one of two
// slaves, sequencing AW then W and keeping B responses in order across slaves.
module axi_wr_route_ctrl #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] S1_BASE         = 32'h4000_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_MASK         = 32'hC000_0000,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter int                    CNT_WIDTH       = 3
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  S_AWVALID,
  input  logic [ADDR_WIDTH-1:0] S_AWADDR,
  output logic                  S_AWREADY,
  input  logic                  S_WVALID,
  input  logic                  S_WLAST,
  output logic                  S_WREADY,
  input  logic                  S_BREADY,
  input  logic                  M0_AWREADY,
  input  logic                  M1_AWREADY,
  input  logic                  M0_WREADY,
  input  logic                  M1_WREADY,
  input  logic                  M0_BVALID,
  input  logic                  M1_BVALID,
  output logic                  aw_sel,
  output logic                  aw_en,
  output logic                  w_sel,
  output logic                  w_en,
  output logic                  b_sel,
  output logic                  b_en,
  output logic [CNT_WIDTH-1:0]  outstanding_cnt,
  output logic                  busy,
  output logic                  err_stray_b
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 cur_sel_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] cnt_nxt_s;
  logic                 err_r;
  logic                 dec_sel_s;
  logic                 allow_s;
  logic                 awready_s;
  logic                 wready_s;
  logic                 aw_hs_s;
  logic                 b_hs_s;
  logic                 stray_s;

  assign dec_sel_s = ((S_AWADDR & S1_MASK) == S1_BASE);
  // A slave switch waits for the count to drain so B responses cannot reorder.
  assign allow_s   = (cnt_r == CNT_ZERO) ||
                     ((dec_sel_s == cur_sel_r) && (cnt_r < MAX_CNT));
  assign aw_hs_s   = (state_r == ADDR) && S_AWVALID && awready_s;
  assign b_en      = (cnt_r != CNT_ZERO);
  assign b_sel     = cur_sel_r;
  assign b_hs_s    = b_en && (cur_sel_r ? M1_BVALID : M0_BVALID) && S_BREADY;
  assign stray_s   = (cnt_r == CNT_ZERO) ? (M0_BVALID || M1_BVALID)
                                         : (cur_sel_r ? M0_BVALID : M1_BVALID);

  assign S_AWREADY       = awready_s;
  assign S_WREADY        = wready_s;
  assign outstanding_cnt = cnt_r;
  assign err_stray_b     = err_r;
  assign busy            = (state_r != IDLE) || (cnt_r != CNT_ZERO);

  // Next-state logic and per-state demux enables/selects and readies.
  always_comb begin
    state_nxt_s = state_r;
    aw_en       = 1'b0;
    aw_sel      = 1'b0;
    w_en        = 1'b0;
    w_sel       = 1'b0;
    awready_s   = 1'b0;
    wready_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (S_AWVALID && allow_s) begin
          state_nxt_s = ADDR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ADDR: begin
        aw_en     = 1'b1;
        aw_sel    = cur_sel_r;
        awready_s = cur_sel_r ? M1_AWREADY : M0_AWREADY;
        if (S_AWVALID && awready_s) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = ADDR;
        end
      end
      DATA: begin
        w_en     = 1'b1;
        w_sel    = cur_sel_r;
        wready_s = cur_sel_r ? M1_WREADY : M0_WREADY;
        if (S_WVALID && wready_s && S_WLAST) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DATA;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outstanding-response count; simultaneous AW and B handshakes cancel out.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (aw_hs_s && !b_hs_s) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else if (b_hs_s && !aw_hs_s) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State, target slave, count and sticky stray-B flag registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r   <= IDLE;
      cur_sel_r <= 1'b0;
      cnt_r     <= CNT_ZERO;
      err_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if ((state_r == IDLE) && S_AWVALID && allow_s) begin
        cur_sel_r <= dec_sel_s;
      end
      if (stray_s) begin
        err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_route_ctrl.sv
// Directed self-checking bench for axi_wr_route_ctrl: inputs change 1ns after the
// rising edge, outputs are compared 1ns later, well before the next edge.
module tb_axi_wr_route_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        S_AWVALID;
  logic [31:0] S_AWADDR;
  logic        S_AWREADY;
  logic        S_WVALID;
  logic        S_WLAST;
  logic        S_WREADY;
  logic        S_BREADY;
  logic        M0_AWREADY, M1_AWREADY;
  logic        M0_WREADY, M1_WREADY;
  logic        M0_BVALID, M1_BVALID;
  logic        aw_sel, aw_en, w_sel, w_en, b_sel, b_en;
  logic [2:0]  outstanding_cnt;
  logic        busy;
  logic        err_stray_b;

  int errors = 0;
  int checks = 0;

  always #5 ACLK = ~ACLK;

  axi_wr_route_ctrl dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWVALID(S_AWVALID), .S_AWADDR(S_AWADDR), .S_AWREADY(S_AWREADY),
    .S_WVALID(S_WVALID), .S_WLAST(S_WLAST), .S_WREADY(S_WREADY),
    .S_BREADY(S_BREADY),
    .M0_AWREADY(M0_AWREADY), .M1_AWREADY(M1_AWREADY),
    .M0_WREADY(M0_WREADY), .M1_WREADY(M1_WREADY),
    .M0_BVALID(M0_BVALID), .M1_BVALID(M1_BVALID),
    .aw_sel(aw_sel), .aw_en(aw_en), .w_sel(w_sel), .w_en(w_en),
    .b_sel(b_sel), .b_en(b_en),
    .outstanding_cnt(outstanding_cnt), .busy(busy), .err_stray_b(err_stray_b)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Full single-beat write to addr, leaving the B response pending.
  task automatic single_write(input logic [31:0] addr);
    S_AWADDR = addr; S_AWVALID = 1'b1;
    tick();                       // IDLE -> ADDR
    tick();                       // ADDR -> DATA
    S_AWVALID = 1'b0; S_WVALID = 1'b1; S_WLAST = 1'b1;
    tick();                       // DATA -> IDLE
    S_WVALID = 1'b0; S_WLAST = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1; S_AWVALID = 1'b0; S_AWADDR = 32'h0; S_WVALID = 1'b0; S_WLAST = 1'b0;
    S_BREADY = 1'b0; M0_AWREADY = 1'b1; M1_AWREADY = 1'b1; M0_WREADY = 1'b1;
    M1_WREADY = 1'b1; M0_BVALID = 1'b0; M1_BVALID = 1'b0;
    tick(); tick();
    ARESET = 1'b0;
    #1;
    checks++;
    if ({aw_en, aw_sel, w_en, w_sel, b_en, b_sel, S_AWREADY, S_WREADY} !== 8'h00) begin
      errors++; $display("FAIL reset_ctl got=%b exp=00000000",
                         {aw_en, aw_sel, w_en, w_sel, b_en, b_sel, S_AWREADY, S_WREADY});
    end
    checks++;
    if ({busy, err_stray_b, outstanding_cnt} !== 5'b00000) begin
      errors++; $display("FAIL reset_stat got=%b exp=00000", {busy, err_stray_b, outstanding_cnt});
    end
  endtask

  task automatic test_single_s1();
    S_BREADY = 1'b1; S_AWADDR = 32'h4000_0010; S_AWVALID = 1'b1;
    #1;
    checks++;
    if (S_AWREADY !== 1'b0) begin errors++; $display("FAIL s1_idle_awready got=%b exp=0", S_AWREADY); end
    tick();
    checks++;
    if ({aw_en, aw_sel, S_AWREADY, w_en} !== 4'b1110) begin
      errors++; $display("FAIL s1_addr got=%b exp=1110", {aw_en, aw_sel, S_AWREADY, w_en});
    end
    tick();
    S_AWVALID = 1'b0; S_WVALID = 1'b1; M1_WREADY = 1'b0;
    #1;
    checks++;
    if ({w_en, w_sel, S_WREADY, aw_en, outstanding_cnt} !== 7'b1100_001) begin
      errors++; $display("FAIL s1_wstall got=%b exp=1100001", {w_en, w_sel, S_WREADY, aw_en, outstanding_cnt});
    end
    tick();
    M1_WREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      S_WLAST = (i == 3);
      #1;
      checks++;
      if ({w_en, w_sel, S_WREADY} !== 3'b111) begin
        errors++; $display("FAIL s1_beat%0d got=%b exp=111", i, {w_en, w_sel, S_WREADY});
      end
      tick();
    end
    S_WVALID = 1'b0; S_WLAST = 1'b0;
    checks++;
    if ({w_en, b_en, b_sel, busy, outstanding_cnt} !== 7'b0111_001) begin
      errors++; $display("FAIL s1_bwait got=%b exp=0111001", {w_en, b_en, b_sel, busy, outstanding_cnt});
    end
    tick(); tick();
    M1_BVALID = 1'b1;
    tick();
    M1_BVALID = 1'b0;
    checks++;
    if ({busy, b_en, outstanding_cnt, err_stray_b} !== 6'b00_000_0) begin
      errors++; $display("FAIL s1_bdone got=%b exp=000000", {busy, b_en, outstanding_cnt, err_stray_b});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) single_write(32'h0000_1000);
    checks++;
    if (outstanding_cnt !== 3'd4) begin errors++; $display("FAIL b2b_cnt4 got=%0d exp=4", outstanding_cnt); end
    S_AWADDR = 32'h0000_1000; S_AWVALID = 1'b1;
    tick(); tick();
    checks++;
    if ({aw_en, S_AWREADY, outstanding_cnt} !== 5'b00_100) begin
      errors++; $display("FAIL b2b_held got=%b exp=00100", {aw_en, S_AWREADY, outstanding_cnt});
    end
    M0_BVALID = 1'b1;
    tick();
    M0_BVALID = 1'b0;
    checks++;
    if ({aw_en, outstanding_cnt} !== 4'b0_011) begin
      errors++; $display("FAIL b2b_release got=%b exp=0011", {aw_en, outstanding_cnt});
    end
    tick();
    checks++;
    if ({aw_en, aw_sel, S_AWREADY} !== 3'b101) begin
      errors++; $display("FAIL b2b_fifth_addr got=%b exp=101", {aw_en, aw_sel, S_AWREADY});
    end
    tick();
    S_AWVALID = 1'b0; S_WVALID = 1'b1; S_WLAST = 1'b1;
    tick();
    S_WVALID = 1'b0; S_WLAST = 1'b0;
    checks++;
    if (outstanding_cnt !== 3'd4) begin errors++; $display("FAIL b2b_cnt_back4 got=%0d exp=4", outstanding_cnt); end
    M0_BVALID = 1'b1;
    tick(); tick(); tick(); tick();
    M0_BVALID = 1'b0;
    checks++;
    if ({outstanding_cnt, busy, err_stray_b} !== 5'b000_0_0) begin
      errors++; $display("FAIL b2b_drain got=%b exp=00000", {outstanding_cnt, busy, err_stray_b});
    end
  endtask

  task automatic test_slave_switch();
    single_write(32'h0000_0000);
    S_AWADDR = 32'h4000_0000; S_AWVALID = 1'b1;
    tick(); tick();
    checks++;
    if ({aw_en, outstanding_cnt} !== 4'b0_001) begin
      errors++; $display("FAIL sw_stall got=%b exp=0001", {aw_en, outstanding_cnt});
    end
    M0_BVALID = 1'b1;
    tick();
    M0_BVALID = 1'b0;
    checks++;
    if ({aw_en, outstanding_cnt} !== 4'b0_000) begin
      errors++; $display("FAIL sw_bret got=%b exp=0000", {aw_en, outstanding_cnt});
    end
    tick();
    checks++;
    if ({aw_en, aw_sel, S_AWREADY} !== 3'b111) begin
      errors++; $display("FAIL sw_addr_s1 got=%b exp=111", {aw_en, aw_sel, S_AWREADY});
    end
    tick();
    S_AWVALID = 1'b0; S_WVALID = 1'b1; S_WLAST = 1'b1;
    tick();
    S_WVALID = 1'b0; S_WLAST = 1'b0;
    checks++;
    if ({outstanding_cnt, b_sel, err_stray_b} !== 5'b001_1_0) begin
      errors++; $display("FAIL sw_done got=%b exp=00110", {outstanding_cnt, b_sel, err_stray_b});
    end
  endtask

  task automatic test_simultaneous();
    logic [5:0] rdy_pat;
    logic [5:0] last_pat;
    single_write(32'h4000_0000);
    S_AWADDR = 32'h4000_0000; S_AWVALID = 1'b1;
    tick();
    M1_BVALID = 1'b1;
    #1;
    checks++;
    if ({aw_en, S_AWREADY, outstanding_cnt} !== 5'b11_010) begin
      errors++; $display("FAIL sim_pre got=%b exp=11010", {aw_en, S_AWREADY, outstanding_cnt});
    end
    tick();
    M1_BVALID = 1'b0; S_AWVALID = 1'b0;
    checks++;
    if ({w_en, outstanding_cnt} !== 4'b1_010) begin
      errors++; $display("FAIL sim_aw_b got=%b exp=1010", {w_en, outstanding_cnt});
    end
    S_WVALID = 1'b1; S_WLAST = 1'b1;
    tick();
    S_WVALID = 1'b0; S_WLAST = 1'b0;
    M1_BVALID = 1'b1;
    tick(); tick();
    M1_BVALID = 1'b0;
    checks++;
    if (outstanding_cnt !== 3'd0) begin errors++; $display("FAIL sim_drain got=%0d exp=0", outstanding_cnt); end
    // W backpressure: beats accepted at idx 0,2,3,5; WLAST first offered at idx 4 while not ready.
    rdy_pat  = 6'b101101;
    last_pat = 6'b110000;
    S_AWADDR = 32'h0000_0040; S_AWVALID = 1'b1;
    tick(); tick();
    S_AWVALID = 1'b0; S_WVALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      M0_WREADY = rdy_pat[i];
      S_WLAST   = last_pat[i];
      #1;
      checks++;
      if ({w_en, w_sel, S_WREADY} !== {1'b1, 1'b0, rdy_pat[i]}) begin
        errors++; $display("FAIL bp_idx%0d got=%b exp=10%b", i, {w_en, w_sel, S_WREADY}, rdy_pat[i]);
      end
      tick();
    end
    S_WVALID = 1'b0; S_WLAST = 1'b0; M0_WREADY = 1'b1;
    checks++;
    if ({w_en, S_WREADY, outstanding_cnt} !== 5'b00_001) begin
      errors++; $display("FAIL bp_exit got=%b exp=00001", {w_en, S_WREADY, outstanding_cnt});
    end
  endtask

  task automatic test_stray_and_reset();
    M0_BVALID = 1'b1;
    tick();
    M0_BVALID = 1'b0;
    checks++;
    if ({outstanding_cnt, err_stray_b} !== 4'b000_0) begin
      errors++; $display("FAIL st_pre got=%b exp=0000", {outstanding_cnt, err_stray_b});
    end
    M1_BVALID = 1'b1;
    tick();
    M1_BVALID = 1'b0;
    checks++;
    if ({err_stray_b, outstanding_cnt} !== 4'b1_000) begin
      errors++; $display("FAIL st_set got=%b exp=1000", {err_stray_b, outstanding_cnt});
    end
    tick(); tick();
    checks++;
    if (err_stray_b !== 1'b1) begin errors++; $display("FAIL st_sticky got=%b exp=1", err_stray_b); end
    S_AWADDR = 32'h0000_0100; S_AWVALID = 1'b1;
    tick(); tick();
    S_AWVALID = 1'b0; S_WVALID = 1'b1; S_WLAST = 1'b0;
    tick();
    checks++;
    if ({w_en, outstanding_cnt} !== 4'b1_001) begin
      errors++; $display("FAIL rst_beat2 got=%b exp=1001", {w_en, outstanding_cnt});
    end
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0; S_WVALID = 1'b0;
    checks++;
    if ({w_en, S_WREADY, aw_en, busy, err_stray_b, outstanding_cnt} !== 8'b00000_000) begin
      errors++; $display("FAIL rst_mid got=%b exp=00000000",
                         {w_en, S_WREADY, aw_en, busy, err_stray_b, outstanding_cnt});
    end
  endtask

  initial begin
    test_reset();
    test_single_s1();
    test_back_to_back();
    test_slave_switch();
    test_simultaneous();
    test_stray_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
